up_dn_cntr_arb: RTL and testbench
=================================

Name: up_dn_cntr_arb

Overview:
Round-robin arbiter and sequencer that shares one saturating up/down counter among NREQ requesters.
- Each cycle at most one requester's up or down step is applied to the shared counter.
- A requester may hold ownership for a locked burst of up to MAXBURST steps.
- Sits between the requesting agents and the shared counter; broadcasts the counter value and a per-requester grant/saturation status.

Parameters:
NREQ, 4, number of requesters (>=2)
CW, 4, counter width in bits
MAXBURST, 4, max consecutive grants to one locked owner (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester step request, level
dir  input  NREQ  per-requester direction: 1 up, 0 down
lock  input  NREQ  per-requester burst lock; sampled with req
gnt  output  NREQ  registered one-hot; gnt[i]=1 in the cycle after requester i's step was applied
sat_hit  output  1  registered; 1 with gnt when the applied step was blocked by saturation
cntr  output  CW  shared counter value, registered
busy  output  1  1 while in state OWN

Behaviour:
- Reset (async, rst=1): cntr=0, gnt=0, sat_hit=0, busy=0, state=IDLE, ptr=0, owner=0, bcnt=0. Reset mid-burst abandons the burst with no step applied.
- Shared counter: step only when a grant is issued.
  - Up at all-ones holds, with sat_hit=1.
  - Down at zero holds, with sat_hit=1.
  - Otherwise +/-1, with sat_hit=0.
  - No wrap-around ever.
- Latency: req sampled at edge t; cntr, gnt and sat_hit update at the same edge t. Requester sees gnt/cntr during cycle t+1.
- Requester protocol: a requester still asserting req in the cycle it sees gnt is treated as a new request. No implicit dedup.
- State IDLE:
  - Winner w = first i with req[i]=1, searching ptr, ptr+1, ... mod NREQ. No req: no step, gnt=0.
  - Apply dir[w] step and set gnt[w].
  - If lock[w]=1 and MAXBURST>1: go to OWN, owner=w, bcnt=1.
  - Else: ptr=(w+1) mod NREQ, stay in IDLE.
- State OWN, busy=1; only owner is eligible, others are ignored:
  - req[owner]=0: no step, go to IDLE, ptr=owner+1.
  - req[owner]=1: apply dir[owner] step, gnt[owner], bcnt+1.
    - Go to IDLE with ptr=owner+1 if lock[owner]=0 or bcnt+1==MAXBURST.
    - Otherwise stay in OWN.
  - Result: the owner gets at most MAXBURST consecutive grants; the next arbitration starts after the owner.
- gnt is always one-hot or zero. sat_hit=0 whenever gnt=0.
- dir/lock of non-winning requesters are don't-care.
- ptr width = clog2(NREQ). Wrap ptr explicitly for non-power-of-2 NREQ.

Decomposition:
- Package up_dn_cntr_pkg:
  - state typedef arb_state_e {IDLE, OWN}
  - DIR_UP=1'b1, DIR_DN=1'b0
- Sub-module sat_updn_cntr_en: CW-wide saturating counter with en, dir, async rst; outputs value and combinational sat (en && at limit in dir).
- Top holds the RR pointer, FSM, burst counter and registered gnt/sat_hit.

Test Plan:
1. Fairness: rst then release; req=4'b1111, dir=all up, lock=0 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; cntr 1..8.
2. Saturation: 15 up-grants from requester 0 -> cntr=15. Then one more up -> cntr stays 15, gnt=0001, sat_hit=1. Then dir=0 -> cntr=14, sat_hit=0.
3. Down floor: from cntr=0, requester 2 dir=0 -> cntr=0, gnt=0100, sat_hit=1.
4. Burst cap: req=1111 with lock[1]=1, all others also requesting, MAXBURST=4, ptr=1 -> gnt=0010 for 4 cycles, busy=1 for the first 3 cycle-ends, then gnt=0100; cntr +4 then +1.
5. Early release: owner 3 drops req after 2 grants -> one idle cycle (gnt=0), busy falls, next grant to requester 0.
6. Reset mid-burst: assert rst asynchronously during OWN with cntr=9 -> cntr=0, gnt=0, busy=0 immediately. After release, first grant goes to requester 0.

Source files
------------

// File: rtl/up_dn_cntr_pkg.sv
// Shared types and constants for the up/down counter arbiter.
package up_dn_cntr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage : up_dn_cntr_pkg

// File: rtl/up_dn_cntr_arb_sat_updn_cntr_en.sv
// CW-wide saturating up/down counter; sat_c flags a step blocked at a limit.
module sat_updn_cntr_en
  import up_dn_cntr_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  output logic [CW-1:0] value,
  output logic          sat_c
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next value: step by one unless already at the limit in the step direction.
  always_comb begin
    cnt_d = cnt_q;
    sat_c = 1'b0;
    if (en) begin
      if (dir == DIR_UP) begin
        if (cnt_q == {CW{1'b1}}) sat_c = 1'b1;
        else                     cnt_d = cnt_q + CW'(1);
      end else begin
        if (cnt_q == '0) sat_c = 1'b1;
        else             cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule : sat_updn_cntr_en

// File: rtl/up_dn_cntr_arb.sv
// Round-robin arbiter sharing one saturating counter, with locked bursts.
module up_dn_cntr_arb
  import up_dn_cntr_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned CW       = 4,
  parameter int unsigned MAXBURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] dir,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] gnt,
  output logic            sat_hit,
  output logic [CW-1:0]   cntr,
  output logic            busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(MAXBURST + 1);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            sat_hit_q, sat_hit_d;
  logic            busy_q, busy_d;

  logic            step;
  logic            step_dir;
  logic            sat_c;
  logic            found;
  logic [PW-1:0]   win;
  int unsigned     idx;

  // Successor index with explicit wrap for non-power-of-2 NREQ.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (32'(v) + 32'd1 >= NREQ) return '0;
    else                        return v + PW'(1);
  endfunction

  // Round-robin search starting at ptr for the first active request.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Arbitration FSM: pick a step source, advance pointer and burst tracking.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    bcnt_d   = bcnt_q;
    gnt_d    = '0;
    step     = 1'b0;
    step_dir = DIR_UP;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          step       = 1'b1;
          step_dir   = dir[win];
          gnt_d[win] = 1'b1;
          if (lock[win] && (MAXBURST > 32'd1)) begin
            state_d = OWN;
            owner_d = win;
            bcnt_d  = BW'(1);
          end else begin
            ptr_d = wrap_inc(win);
          end
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q);
        end else begin
          step           = 1'b1;
          step_dir       = dir[owner_q];
          gnt_d[owner_q] = 1'b1;
          bcnt_d         = bcnt_q + BW'(1);
          if (!lock[owner_q] || (bcnt_q + BW'(1) == BW'(MAXBURST))) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    sat_hit_d = sat_c;
    busy_d    = (state_d == OWN);
  end

  // Arbiter state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      bcnt_q    <= '0;
      gnt_q     <= '0;
      sat_hit_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      bcnt_q    <= bcnt_d;
      gnt_q     <= gnt_d;
      sat_hit_q <= sat_hit_d;
      busy_q    <= busy_d;
    end
  end

  sat_updn_cntr_en #(.CW(CW)) u_cntr (
    .clk   (clk),
    .rst   (rst),
    .en    (step),
    .dir   (step_dir),
    .value (cntr),
    .sat_c (sat_c)
  );

  assign gnt     = gnt_q;
  assign sat_hit = sat_hit_q;
  assign busy    = busy_q;

endmodule : up_dn_cntr_arb

// File: tb/tb_up_dn_cntr_arb.sv
// Scoreboard bench for up_dn_cntr_arb against a behavioural arbitration model.
module tb_up_dn_cntr_arb;

  localparam int NREQ     = 4;
  localparam int CW       = 4;
  localparam int MAXBURST = 4;
  localparam int CMAX     = (1 << CW) - 1;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            sat;
    logic [CW-1:0]   cntr;
    logic            busy;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] dir = '0;
  logic [NREQ-1:0] lock = '0;
  logic [NREQ-1:0] gnt;
  logic            sat_hit;
  logic [CW-1:0]   cntr;
  logic            busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Model state: counter value, next-search start, burst owner and grants taken.
  int m_cnt = 0, m_ptr = 0, m_owner = 0, m_taken = 0;
  bit m_owned = 0;

  up_dn_cntr_arb #(.NREQ(NREQ), .CW(CW), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .lock(lock),
    .gnt(gnt), .sat_hit(sat_hit), .cntr(cntr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_ptr = 0; m_owner = 0; m_taken = 0; m_owned = 0;
  endtask

  task automatic apply_step(input logic up, output logic s);
    s = 1'b0;
    if (up) begin
      if (m_cnt == CMAX) s = 1'b1; else m_cnt = m_cnt + 1;
    end else begin
      if (m_cnt == 0) s = 1'b1; else m_cnt = m_cnt - 1;
    end
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, d, l, output exp_t e);
    logic s;
    int   w;
    e = '0;
    if (m_owned) begin
      if (!r[m_owner]) begin
        m_owned = 0;
        m_ptr   = (m_owner + 1) % NREQ;
      end else begin
        apply_step(d[m_owner], s);
        e.gnt[m_owner] = 1'b1;
        e.sat          = s;
        m_taken++;
        if (!l[m_owner] || m_taken == MAXBURST) begin
          m_owned = 0;
          m_ptr   = (m_owner + 1) % NREQ;
        end
      end
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        apply_step(d[w], s);
        e.gnt[w] = 1'b1;
        e.sat    = s;
        if (l[w] && MAXBURST > 1) begin
          m_owned = 1; m_owner = w; m_taken = 1;
        end else begin
          m_ptr = (w + 1) % NREQ;
        end
      end
    end
    e.cntr = CW'(m_cnt);
    e.busy = m_owned;
  endtask

  // One cycle of stimulus; expected response goes to the scoreboard.
  task automatic drive(input logic [NREQ-1:0] r, d, l);
    exp_t e;
    @(negedge clk);
    req = r; dir = d; lock = l;
    model_step(r, d, l, e);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string name);
    n_checks++;
    if (gnt !== '0 || sat_hit !== 1'b0 || cntr !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b sat=%b cntr=%0d busy=%b, want all zero",
               name, gnt, sat_hit, cntr, busy);
    end
  endtask

  // Monitor: compare the DUT outputs after every edge that has an expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== e.gnt || sat_hit !== e.sat || cntr !== e.cntr || busy !== e.busy) begin
        n_fail++;
        $display("FAIL cycle@%0t: got gnt=%b sat=%b cntr=%0d busy=%b, want gnt=%b sat=%b cntr=%0d busy=%b",
                 $time, gnt, sat_hit, cntr, busy, e.gnt, e.sat, e.cntr, e.busy);
      end
    end
  end

  initial begin
    // Power-on reset.
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    model_reset();

    // Fairness: all request up, no lock.
    repeat (8) drive(4'b1111, 4'b1111, 4'b0000);

    // Saturation at the top, then one step down.
    repeat (16) drive(4'b0001, 4'b1111, 4'b0000);
    drive(4'b0001, 4'b0000, 4'b0000);

    // Floor at zero from requester 2.
    repeat (16) drive(4'b0100, 4'b0000, 4'b0000);

    // Burst cap: place ptr at 1, then requester 1 locks with everyone requesting.
    drive(4'b0001, 4'b1111, 4'b0000);
    repeat (6) drive(4'b1111, 4'b1111, 4'b0010);

    // Early release: owner 3 drops after two grants.
    repeat (2) drive(4'b1000, 4'b1111, 4'b1000);
    repeat (2) drive(4'b0001, 4'b1111, 4'b0000);

    // Reset mid-burst: reach cntr=9 while owning, then assert reset between edges.
    repeat (2) drive(4'b0000, 4'b0000, 4'b0000);
    repeat (14) drive(4'b0001, 4'b0000, 4'b0000);
    repeat (8) drive(4'b0001, 4'b1111, 4'b0000);
    drive(4'b0100, 4'b1111, 4'b0100);
    @(negedge clk);
    #2;
    rst = 1'b1; req = '0; dir = '0; lock = '0;
    #1;
    check_reset_state("reset_mid_burst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1111, 4'b1111, 4'b0000);

    // Randomized traffic with frequent locks.
    for (int i = 0; i < 400; i++)
      drive(NREQ'($urandom), NREQ'($urandom), NREQ'($urandom) | NREQ'($urandom));

    repeat (3) drive(4'b0000, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_up_dn_cntr_arb
